// File: rtl/id_stage_pipe_if.sv
// Handshake/bus bundle for the decode stage: IF/ID request side and the
// registered ID/EX result side. The decode stage is the master.
interface id_stage_pipe_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
);
  // IF/ID side
  logic                  valid_i;
  logic                  ready_o;
  logic [31:0]           pc_i;
  logic [31:0]           inst_i;
  // ID/EX side
  logic                  valid_o;
  logic                  ready_i;
  logic [31:0]           pc_o;
  logic [7:0]            aluop_o;
  logic [2:0]            alusel_o;
  logic [DATA_W-1:0]     reg1_o;
  logic [DATA_W-1:0]     reg2_o;
  logic                  wreg_o;
  logic [REG_ADDR_W-1:0] wd_o;

  modport master (
    input  valid_i, pc_i, inst_i, ready_i,
    output ready_o, valid_o, pc_o, aluop_o, alusel_o, reg1_o, reg2_o, wreg_o, wd_o
  );

  modport slave (
    output valid_i, pc_i, inst_i, ready_i,
    input  ready_o, valid_o, pc_o, aluop_o, alusel_o, reg1_o, reg2_o, wreg_o, wd_o
  );
endinterface

// File: rtl/id_stage_pipe.sv
// Pipelined MIPS decode stage: decodes one instruction per cycle, reads the
// register file with EX/MEM/WB forwarding, detects load-use hazards and
// presents a registered valid/ready ID/EX bundle.
module id_stage_pipe #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int FWD_EN     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  id_stage_pipe_if.master       bus,
  input  logic                  flush_i,
  input  logic                  we_i,
  input  logic [REG_ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic                  ex_wreg_i,
  input  logic [REG_ADDR_W-1:0] ex_wd_i,
  input  logic [DATA_W-1:0]     ex_wdata_i,
  input  logic                  ex_is_load_i,
  input  logic                  mem_wreg_i,
  input  logic [REG_ADDR_W-1:0] mem_wd_i,
  input  logic [DATA_W-1:0]     mem_wdata_i
);
  localparam int DEPTH = 2 ** REG_ADDR_W;

  localparam logic [7:0] OP_NOP   = 8'h00, OP_AND = 8'h24, OP_OR  = 8'h25,
                         OP_XOR   = 8'h26, OP_NOR = 8'h27, OP_ADDU = 8'h21,
                         OP_SUBU  = 8'h23, OP_SLL = 8'h7C, OP_SRL = 8'h02,
                         OP_SRA   = 8'h03, OP_ADDIU = 8'h56;
  localparam logic [2:0] SEL_NOP = 3'b000, SEL_LOGIC = 3'b001,
                         SEL_SHIFT = 3'b010, SEL_ARITH = 3'b100;

  function automatic logic [DATA_W-1:0] zext16(input logic [15:0] v);
    return {{(DATA_W-16){1'b0}}, v};
  endfunction

  function automatic logic [DATA_W-1:0] sext16(input logic [15:0] v);
    return {{(DATA_W-16){v[15]}}, v};
  endfunction

  function automatic logic [DATA_W-1:0] lui16(input logic [15:0] v);
    return {v, {(DATA_W-16){1'b0}}};
  endfunction

  logic [DATA_W-1:0] rf_q [DEPTH];
  logic [DATA_W-1:0] rf_d [DEPTH];

  logic [5:0]            opc, fn;
  logic [REG_ADDR_W-1:0] rs, rt, rd;
  logic [7:0]            aluop_dec;
  logic [2:0]            alusel_dec;
  logic                  wreg_dec, re1, re2;
  logic [REG_ADDR_W-1:0] wd_dec;
  logic [DATA_W-1:0]     op1_imm, op2_imm;

  logic [REG_ADDR_W-1:0] src_addr [2];
  logic                  src_re   [2];
  logic [DATA_W-1:0]     src_val  [2];
  logic                  stall, ready, accept;

  logic                  valid_q, valid_d, wreg_q, wreg_d;
  logic [31:0]           pc_q, pc_d;
  logic [7:0]            aluop_q, aluop_d;
  logic [2:0]            alusel_q, alusel_d;
  logic [DATA_W-1:0]     reg1_q, reg1_d, reg2_q, reg2_d;
  logic [REG_ADDR_W-1:0] wd_q, wd_d;

  assign opc = bus.inst_i[31:26];
  assign fn  = bus.inst_i[5:0];
  assign rs  = REG_ADDR_W'(bus.inst_i[25:21]);
  assign rt  = REG_ADDR_W'(bus.inst_i[20:16]);
  assign rd  = REG_ADDR_W'(bus.inst_i[15:11]);

  // Register file next state: WB write, $0 stays hard-wired to zero
  always_comb begin
    rf_d = rf_q;
    if (we_i && (waddr_i != '0)) rf_d[waddr_i] = wdata_i;
  end

  // Register file state, cleared on reset
  always_ff @(posedge clk) begin
    if (rst) rf_q <= '{default: '0};
    else     rf_q <= rf_d;
  end

  // Instruction decode: operation, destination, read enables, immediates
  always_comb begin
    aluop_dec  = OP_NOP;
    alusel_dec = SEL_NOP;
    wreg_dec   = 1'b0;
    wd_dec     = '0;
    re1        = 1'b0;
    re2        = 1'b0;
    op1_imm    = '0;
    op2_imm    = '0;
    case (opc)
      6'b001101: begin aluop_dec = OP_OR;  alusel_dec = SEL_LOGIC; wreg_dec = 1'b1; wd_dec = rt; re1 = 1'b1; op2_imm = zext16(bus.inst_i[15:0]); end
      6'b001100: begin aluop_dec = OP_AND; alusel_dec = SEL_LOGIC; wreg_dec = 1'b1; wd_dec = rt; re1 = 1'b1; op2_imm = zext16(bus.inst_i[15:0]); end
      6'b001110: begin aluop_dec = OP_XOR; alusel_dec = SEL_LOGIC; wreg_dec = 1'b1; wd_dec = rt; re1 = 1'b1; op2_imm = zext16(bus.inst_i[15:0]); end
      6'b001111: begin aluop_dec = OP_OR;  alusel_dec = SEL_LOGIC; wreg_dec = 1'b1; wd_dec = rt; op2_imm = lui16(bus.inst_i[15:0]); end
      6'b001001: begin aluop_dec = OP_ADDIU; alusel_dec = SEL_ARITH; wreg_dec = 1'b1; wd_dec = rt; re1 = 1'b1; op2_imm = sext16(bus.inst_i[15:0]); end
      6'b000000: begin
        wd_dec = rd;
        case (fn)
          6'b100100: begin aluop_dec = OP_AND;  alusel_dec = SEL_LOGIC; wreg_dec = 1'b1; re1 = 1'b1; re2 = 1'b1; end
          6'b100101: begin aluop_dec = OP_OR;   alusel_dec = SEL_LOGIC; wreg_dec = 1'b1; re1 = 1'b1; re2 = 1'b1; end
          6'b100110: begin aluop_dec = OP_XOR;  alusel_dec = SEL_LOGIC; wreg_dec = 1'b1; re1 = 1'b1; re2 = 1'b1; end
          6'b100111: begin aluop_dec = OP_NOR;  alusel_dec = SEL_LOGIC; wreg_dec = 1'b1; re1 = 1'b1; re2 = 1'b1; end
          6'b100001: begin aluop_dec = OP_ADDU; alusel_dec = SEL_ARITH; wreg_dec = 1'b1; re1 = 1'b1; re2 = 1'b1; end
          6'b100011: begin aluop_dec = OP_SUBU; alusel_dec = SEL_ARITH; wreg_dec = 1'b1; re1 = 1'b1; re2 = 1'b1; end
          6'b000000: begin aluop_dec = OP_SLL;  alusel_dec = SEL_SHIFT; wreg_dec = 1'b1; re2 = 1'b1; op1_imm = {{(DATA_W-5){1'b0}}, bus.inst_i[10:6]}; end
          6'b000010: begin aluop_dec = OP_SRL;  alusel_dec = SEL_SHIFT; wreg_dec = 1'b1; re2 = 1'b1; op1_imm = {{(DATA_W-5){1'b0}}, bus.inst_i[10:6]}; end
          6'b000011: begin aluop_dec = OP_SRA;  alusel_dec = SEL_SHIFT; wreg_dec = 1'b1; re2 = 1'b1; op1_imm = {{(DATA_W-5){1'b0}}, bus.inst_i[10:6]}; end
          default:   wd_dec = '0;
        endcase
      end
      default: wd_dec = '0;
    endcase
  end

  // Operand fetch with EX > MEM > WB > regfile priority, plus hazard detection
  always_comb begin
    src_addr[0] = rs;
    src_addr[1] = rt;
    src_re[0]   = re1;
    src_re[1]   = re2;
    stall       = 1'b0;
    for (int s = 0; s < 2; s++) begin
      src_val[s] = rf_q[src_addr[s]];
      if (we_i && (waddr_i == src_addr[s])) src_val[s] = wdata_i;
      if (FWD_EN != 0) begin
        if (mem_wreg_i && (mem_wd_i == src_addr[s])) src_val[s] = mem_wdata_i;
        if (ex_wreg_i && (ex_wd_i == src_addr[s]))   src_val[s] = ex_wdata_i;
      end
      if (src_addr[s] == '0) src_val[s] = '0;
      if (src_re[s] && (src_addr[s] != '0)) begin
        if (ex_is_load_i && ex_wreg_i && (ex_wd_i == src_addr[s])) stall = 1'b1;
        if ((FWD_EN == 0) && ((ex_wreg_i && (ex_wd_i == src_addr[s])) ||
                              (mem_wreg_i && (mem_wd_i == src_addr[s])))) stall = 1'b1;
      end
    end
  end

  assign ready       = (!valid_q || bus.ready_i) && !stall && !rst && !flush_i;
  assign accept      = bus.valid_i && ready;
  assign bus.ready_o = ready;

  // ID/EX register next state: flush beats everything, then hold, then load/bubble
  always_comb begin
    valid_d  = valid_q;
    pc_d     = pc_q;
    aluop_d  = aluop_q;
    alusel_d = alusel_q;
    reg1_d   = reg1_q;
    reg2_d   = reg2_q;
    wreg_d   = wreg_q;
    wd_d     = wd_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (!valid_q || bus.ready_i) begin
      valid_d = accept;
      if (accept) begin
        pc_d     = bus.pc_i;
        aluop_d  = aluop_dec;
        alusel_d = alusel_dec;
        reg1_d   = re1 ? src_val[0] : op1_imm;
        reg2_d   = re2 ? src_val[1] : op2_imm;
        wreg_d   = wreg_dec;
        wd_d     = wd_dec;
      end
    end
  end

  // ---- ID/EX stage boundary ----
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      pc_q     <= '0;
      aluop_q  <= '0;
      alusel_q <= '0;
      reg1_q   <= '0;
      reg2_q   <= '0;
      wreg_q   <= 1'b0;
      wd_q     <= '0;
    end else begin
      valid_q  <= valid_d;
      pc_q     <= pc_d;
      aluop_q  <= aluop_d;
      alusel_q <= alusel_d;
      reg1_q   <= reg1_d;
      reg2_q   <= reg2_d;
      wreg_q   <= wreg_d;
      wd_q     <= wd_d;
    end
  end

  assign bus.valid_o  = valid_q;
  assign bus.pc_o     = pc_q;
  assign bus.aluop_o  = aluop_q;
  assign bus.alusel_o = alusel_q;
  assign bus.reg1_o   = reg1_q;
  assign bus.reg2_o   = reg2_q;
  assign bus.wreg_o   = wreg_q;
  assign bus.wd_o     = wd_q;
endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: decode, immediates, forwarding,
// load-use stall, hold, flush and $0 handling. A second instance with
// forwarding disabled shares the stimulus.
module tb_id_stage_pipe;
  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i, ready_i, flush_i;
  logic [31:0] pc_i, inst_i;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [31:0] wdata_i;
  logic        ex_wreg_i, ex_is_load_i, mem_wreg_i;
  logic [4:0]  ex_wd_i, mem_wd_i;
  logic [31:0] ex_wdata_i, mem_wdata_i;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  id_stage_pipe_if #(.DATA_W(32), .REG_ADDR_W(5)) bus_f ();
  id_stage_pipe_if #(.DATA_W(32), .REG_ADDR_W(5)) bus_n ();

  assign bus_f.valid_i = valid_i;
  assign bus_f.pc_i    = pc_i;
  assign bus_f.inst_i  = inst_i;
  assign bus_f.ready_i = ready_i;
  assign bus_n.valid_i = valid_i;
  assign bus_n.pc_i    = pc_i;
  assign bus_n.inst_i  = inst_i;
  assign bus_n.ready_i = ready_i;

  id_stage_pipe #(.DATA_W(32), .REG_ADDR_W(5), .FWD_EN(1)) u_fwd (
    .clk(clk), .rst(rst), .bus(bus_f), .flush_i(flush_i),
    .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
    .ex_wreg_i(ex_wreg_i), .ex_wd_i(ex_wd_i), .ex_wdata_i(ex_wdata_i),
    .ex_is_load_i(ex_is_load_i),
    .mem_wreg_i(mem_wreg_i), .mem_wd_i(mem_wd_i), .mem_wdata_i(mem_wdata_i)
  );

  id_stage_pipe #(.DATA_W(32), .REG_ADDR_W(5), .FWD_EN(0)) u_nofwd (
    .clk(clk), .rst(rst), .bus(bus_n), .flush_i(flush_i),
    .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
    .ex_wreg_i(ex_wreg_i), .ex_wd_i(ex_wd_i), .ex_wdata_i(ex_wdata_i),
    .ex_is_load_i(ex_is_load_i),
    .mem_wreg_i(mem_wreg_i), .mem_wd_i(mem_wd_i), .mem_wdata_i(mem_wdata_i)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] pc, input logic [31:0] inst);
    valid_i = 1'b1;
    pc_i    = pc;
    inst_i  = inst;
  endtask

  initial begin
    rst = 1'b1; valid_i = 1'b0; ready_i = 1'b1; flush_i = 1'b0;
    pc_i = '0; inst_i = '0; we_i = 1'b0; waddr_i = '0; wdata_i = '0;
    ex_wreg_i = 1'b0; ex_is_load_i = 1'b0; ex_wd_i = '0; ex_wdata_i = '0;
    mem_wreg_i = 1'b0; mem_wd_i = '0; mem_wdata_i = '0;
    tick();
    tick();
    check_eq("rst_ready",  {31'b0, bus_f.ready_o}, 32'd0);
    check_eq("rst_valid",  {31'b0, bus_f.valid_o}, 32'd0);
    check_eq("rst_pc",     bus_f.pc_o, 32'd0);
    check_eq("rst_reg1",   bus_f.reg1_o, 32'd0);
    check_eq("rst_wreg",   {31'b0, bus_f.wreg_o}, 32'd0);
    rst = 1'b0;
    #1;
    check_eq("idle_ready", {31'b0, bus_f.ready_o}, 32'd1);

    // pre-load $1 via WB
    we_i = 1'b1; waddr_i = 5'd1; wdata_i = 32'h1234_0000;
    tick();
    we_i = 1'b0;

    // ORI $1,$1,0xFF
    issue(32'h100, 32'h3421_00FF);
    tick();
    check_eq("ori_valid",  {31'b0, bus_f.valid_o}, 32'd1);
    check_eq("ori_pc",     bus_f.pc_o, 32'h100);
    check_eq("ori_reg1",   bus_f.reg1_o, 32'h1234_0000);
    check_eq("ori_reg2",   bus_f.reg2_o, 32'h0000_00FF);
    check_eq("ori_wreg",   {31'b0, bus_f.wreg_o}, 32'd1);
    check_eq("ori_wd",     {27'b0, bus_f.wd_o}, 32'd1);
    check_eq("ori_aluop",  {24'b0, bus_f.aluop_o}, 32'h25);
    check_eq("ori_alusel", {29'b0, bus_f.alusel_o}, 32'd1);

    // ADDIU $2,$1,-1
    issue(32'h104, 32'h2422_FFFF);
    tick();
    check_eq("addiu_reg1",  bus_f.reg1_o, 32'h1234_0000);
    check_eq("addiu_reg2",  bus_f.reg2_o, 32'hFFFF_FFFF);
    check_eq("addiu_wd",    {27'b0, bus_f.wd_o}, 32'd2);
    check_eq("addiu_aluop", {24'b0, bus_f.aluop_o}, 32'h56);

    // LUI $3,0xABCD
    issue(32'h108, 32'h3C03_ABCD);
    tick();
    check_eq("lui_reg1", bus_f.reg1_o, 32'd0);
    check_eq("lui_reg2", bus_f.reg2_o, 32'hABCD_0000);
    check_eq("lui_wd",   {27'b0, bus_f.wd_o}, 32'd3);

    // ADDU $4,$1,$2 : EX and MEM both target $1 -> EX wins
    ex_wreg_i = 1'b1; ex_wd_i = 5'd1; ex_wdata_i = 32'hAA;
    mem_wreg_i = 1'b1; mem_wd_i = 5'd1; mem_wdata_i = 32'hBB;
    issue(32'h10C, 32'h0022_2021);
    #1;
    check_eq("nofwd_ready_a", {31'b0, bus_n.ready_o}, 32'd0);
    check_eq("fwd_ready_a",   {31'b0, bus_f.ready_o}, 32'd1);
    tick();
    check_eq("fwd_a_reg1", bus_f.reg1_o, 32'hAA);
    check_eq("fwd_a_reg2", bus_f.reg2_o, 32'd0);

    // EX -> $1, MEM -> $2
    mem_wd_i = 5'd2; mem_wdata_i = 32'hCC;
    issue(32'h110, 32'h0022_2021);
    #1;
    check_eq("nofwd_ready_b", {31'b0, bus_n.ready_o}, 32'd0);
    tick();
    check_eq("fwd_b_reg1",  bus_f.reg1_o, 32'hAA);
    check_eq("fwd_b_reg2",  bus_f.reg2_o, 32'hCC);
    check_eq("addu_aluop",  {24'b0, bus_f.aluop_o}, 32'h21);
    check_eq("addu_alusel", {29'b0, bus_f.alusel_o}, 32'd4);
    check_eq("addu_wd",     {27'b0, bus_f.wd_o}, 32'd4);

    // EX/MEM clear; WB write-through to $2
    ex_wreg_i = 1'b0; mem_wreg_i = 1'b0;
    we_i = 1'b1; waddr_i = 5'd2; wdata_i = 32'h55;
    issue(32'h114, 32'h0022_2021);
    #1;
    check_eq("nofwd_ready_clr", {31'b0, bus_n.ready_o}, 32'd1);
    tick();
    we_i = 1'b0;
    check_eq("wt_reg1", bus_f.reg1_o, 32'h1234_0000);
    check_eq("wt_reg2", bus_f.reg2_o, 32'h55);

    // load-use stall on $1
    ex_wreg_i = 1'b1; ex_is_load_i = 1'b1; ex_wd_i = 5'd1; ex_wdata_i = 32'hDEAD;
    issue(32'h200, 32'h3421_00FF);
    #1;
    check_eq("lu_ready", {31'b0, bus_f.ready_o}, 32'd0);
    tick();
    check_eq("lu_bubble", {31'b0, bus_f.valid_o}, 32'd0);
    ex_wreg_i = 1'b0; ex_is_load_i = 1'b0;
    #1;
    check_eq("lu_ready_clr", {31'b0, bus_f.ready_o}, 32'd1);
    tick();
    check_eq("lu_valid", {31'b0, bus_f.valid_o}, 32'd1);
    check_eq("lu_pc",    bus_f.pc_o, 32'h200);
    check_eq("lu_reg1",  bus_f.reg1_o, 32'h1234_0000);

    // hold for 3 cycles with XORI $6,$2,0x0F0F waiting
    ready_i = 1'b0;
    issue(32'h300, 32'h3846_0F0F);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("hold_ready", {31'b0, bus_f.ready_o}, 32'd0);
      check_eq("hold_valid", {31'b0, bus_f.valid_o}, 32'd1);
      check_eq("hold_pc",    bus_f.pc_o, 32'h200);
      check_eq("hold_reg2",  bus_f.reg2_o, 32'hFF);
    end
    ready_i = 1'b1;
    #1;
    check_eq("rel_ready", {31'b0, bus_f.ready_o}, 32'd1);
    tick();
    check_eq("xori_pc",    bus_f.pc_o, 32'h300);
    check_eq("xori_reg1",  bus_f.reg1_o, 32'h55);
    check_eq("xori_reg2",  bus_f.reg2_o, 32'h0F0F);
    check_eq("xori_wd",    {27'b0, bus_f.wd_o}, 32'd6);
    check_eq("xori_aluop", {24'b0, bus_f.aluop_o}, 32'h26);

    // SRA $7,$2,4
    issue(32'h304, 32'h0002_3903);
    tick();
    check_eq("sra_reg1",   bus_f.reg1_o, 32'd4);
    check_eq("sra_reg2",   bus_f.reg2_o, 32'h55);
    check_eq("sra_aluop",  {24'b0, bus_f.aluop_o}, 32'h03);
    check_eq("sra_alusel", {29'b0, bus_f.alusel_o}, 32'd2);
    check_eq("sra_wd",     {27'b0, bus_f.wd_o}, 32'd7);

    // flush during a hold
    ready_i = 1'b0; flush_i = 1'b1;
    issue(32'h400, 32'h0000_4025);
    #1;
    check_eq("flush_ready", {31'b0, bus_f.ready_o}, 32'd0);
    tick();
    check_eq("flush_valid", {31'b0, bus_f.valid_o}, 32'd0);
    flush_i = 1'b0; ready_i = 1'b1;

    // writes to $0 are ignored, including write-through
    valid_i = 1'b0;
    we_i = 1'b1; waddr_i = 5'd0; wdata_i = 32'hFFFF_FFFF;
    tick();
    issue(32'h500, 32'h0000_4025);
    tick();
    we_i = 1'b0;
    check_eq("r0_valid", {31'b0, bus_f.valid_o}, 32'd1);
    check_eq("r0_reg1",  bus_f.reg1_o, 32'd0);
    check_eq("r0_reg2",  bus_f.reg2_o, 32'd0);
    check_eq("r0_wd",    {27'b0, bus_f.wd_o}, 32'd8);

    // unknown opcode -> NOP in a valid slot
    issue(32'h600, 32'hFC00_0000);
    tick();
    check_eq("nop_valid",  {31'b0, bus_f.valid_o}, 32'd1);
    check_eq("nop_wreg",   {31'b0, bus_f.wreg_o}, 32'd0);
    check_eq("nop_aluop",  {24'b0, bus_f.aluop_o}, 32'h00);
    check_eq("nop_alusel", {29'b0, bus_f.alusel_o}, 32'd0);

    // drain
    valid_i = 1'b0;
    tick();
    check_eq("drain_valid", {31'b0, bus_f.valid_o}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
